rc5_key_expand: RTL and testbench
=================================

# rc5_key_expand

RC5-16 key-schedule engine. It expands a user key into the subkey table S[0..33] that the RC5 encrypt/decrypt datapath consumes. It sits between the host key interface and the cipher core, and drives the core's 34×16-bit subkey array input directly from its internal registers. It runs one cycle per table entry during initialisation and one cycle per mixing iteration.

## Interface
- KEY_WORDS, 8, key length c in 16-bit words (legal 1..16); key is 16*KEY_WORDS bits
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  request expansion; accepted only in IDLE
- num_rounds  in  5  round count r; latched on accept; values >16 treated as 16
- key  in  16*KEY_WORDS  user key; byte k = key[8k+7:8k]; L[i] = key[16i+15:16i]; latched on accept
- subkeys  out  16 x [0:33]  direct view of internal S registers
- busy  out  1  high in INIT, MIX, DONE
- done  out  1  one-cycle pulse in DONE
- subkeys_valid  out  1  set in DONE; cleared on next accepted start or rst

## Operation
- Constants: P16 = 0xB7E1, Q16 = 0x9E37. t = 2*(r'+1), where r' = min(num_rounds,16). Range of t is 2..34. n = 3*max(t, KEY_WORDS).
- All arithmetic is mod 2^16. rotl(x,s) uses s[3:0] only.
- States: IDLE, INIT, MIX, DONE.
- IDLE, start=1: accept. In the same cycle:
  - Latch r', t and n.
  - Load L[0..c-1] from key.
  - Clear all 34 S entries to 0.
  - Set A=B=0, i=j=0, k=0, iteration count=0, subkeys_valid=0.
  - Next state INIT.
- IDLE, start=0: hold all registers.
- INIT: write S[k] = P16 + k*Q16 as a running add (S[k] = S[k-1]+Q16). Then k++. After writing k=t-1, go to MIX. Entries with index ≥ t stay 0.
- MIX, one iteration per cycle:
  - A' = rotl(S[i]+A+B, 3); S[i] = A'
  - B' = rotl(L[j]+A'+B, A'+B); L[j] = B'
  - A=A', B=B'
  - i = (i+1 == t) ? 0 : i+1
  - j = (j+1 == c) ? 0 : j+1
  - After iteration n-1, go to DONE.
- DONE: done=1, subkeys_valid←1, next state IDLE.
- start while busy is ignored; no queuing.
- key and num_rounds may change after accept without effect.
- L is internal only. After DONE, L is don't-care.
- rst at any time, including mid-INIT or mid-MIX:
  - State IDLE.
  - All S entries, L, A, B, i, j and counters go to 0.
  - subkeys_valid=0.
  - No done pulse.

## Timing
- Reset values: subkeys all 0, busy 0, done 0, subkeys_valid 0.
- Take cycle 0 as the cycle in which start=1 is sampled in IDLE.
  - INIT occupies cycles 1..t.
  - MIX occupies cycles t+1..t+n.
  - done=1 in cycle t+n+1.
  - busy=1 in cycles 1..t+n+1.
- Latency start→done is t+n+1 cycles. With c=8:
  - r=0: 27
  - r=12: 105
  - r=16: 137
- subkeys_valid rises together with done and is visible the cycle after DONE. A new start can be accepted in the first IDLE cycle after DONE.
- subkeys reflect register contents every cycle. The consumer uses them only while subkeys_valid=1.
- Back-to-back: start held high continuously restarts in the first IDLE cycle after each DONE.

## Test plan
- Reset and idle:
  - Stimulus: hold rst 3 cycles, then idle.
  - Expected: all outputs 0. start pulsed with rst=1 is not accepted.
- INIT values, r=16, c=8:
  - Stimulus: key=0, start.
  - At end of INIT (cycle 34): S[0]=0xB7E1, S[1]=0x5618, S[2]=0xF44F, S[33]=0x1CF8.
  - busy=1, done=0.
- First MIX step, key=0:
  - After cycle t+1: S[0]=0xBF0D (rotl(0xB7E1,3)). Internal B=0xB7E1.
- Full expansion against a C RC5-16 software model, for each of r ∈ {0, 1, 12, 16, 20}:
  - Random keys.
  - done exactly at cycles 27/29/105/137/137.
  - S[0..t-1] bit-exact; S[t..33]=0.
  - subkeys_valid held until the next start.
- Abort and ignore:
  - rst asserted mid-MIX: next cycle busy=0, subkeys all 0, subkeys_valid=0.
  - start asserted while busy: no effect on latency or result.
- System round trip:
  - Feed subkeys to the cipher core with r=12.
  - Encrypt 0x12345678, then decrypt the result: recovers 0x12345678.

Source files
------------

// File: rtl/rc5_key_expand_if.sv
`default_nettype none
// ============================================================================
// Module      : rc5_key_expand_if
// Description : Host/core-facing bundle of the RC5-16 key-schedule engine.
//               The master (host) drives the key request; the slave (engine)
//               returns the subkey table and status flags.
// Revision    : 1.0 - initial release
// ============================================================================
interface rc5_key_expand_if #(
  parameter int KEY_WORDS = 8
);
  logic                     start;
  logic [4:0]               num_rounds;
  logic [16*KEY_WORDS-1:0]  key;
  logic [0:33][15:0]        subkeys;
  logic                     busy;
  logic                     done;
  logic                     subkeys_valid;

  modport master (
    output start, num_rounds, key,
    input  subkeys, busy, done, subkeys_valid
  );

  modport slave (
    input  start, num_rounds, key,
    output subkeys, busy, done, subkeys_valid
  );
endinterface
`default_nettype wire

// File: rtl/rc5_key_expand.sv
`default_nettype none
// ============================================================================
// Module      : rc5_key_expand
// Description : RC5-16 key-schedule engine. Fills S[0..t-1] with the magic
//               constant sequence (one entry per cycle), then runs the
//               3*max(t,c) mixing iterations (one per cycle). The S registers
//               are exported directly as the subkey table.
// Revision    : 1.0 - initial release
// ============================================================================
module rc5_key_expand #(
  parameter int KEY_WORDS = 8
) (
  input  logic             clk,
  input  logic             rst,
  rc5_key_expand_if.slave  bus
);

  localparam logic [15:0] C_P16   = 16'hB7E1;
  localparam logic [15:0] C_Q16   = 16'h9E37;
  localparam logic [4:0]  C_WORDS = 5'(KEY_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    MIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [0:33][15:0] s_q, s_d;
  logic [0:15][15:0] l_q, l_d;
  logic [15:0]       a_q, a_d;
  logic [15:0]       b_q, b_d;
  logic [5:0]        i_q, i_d;
  logic [5:0]        k_q, k_d;
  logic [5:0]        t_q, t_d;
  logic [3:0]        j_q, j_d;
  logic [6:0]        cnt_q, cnt_d;
  logic [6:0]        n_q, n_d;
  logic              valid_q, valid_d;

  // Left rotate of a 16-bit word; only the low four bits of the amount matter.
  function automatic logic [15:0] rotl16(input logic [15:0] x, input logic [3:0] sh);
    logic [31:0] w;
    w = {x, x} << sh;
    return w[31:16];
  endfunction

  // Key words unpacked from the flat key bus; unused L slots read as zero.
  wire [0:15][15:0] key_words;
  for (genvar w = 0; w < 16; w++) begin : g_key_word
    if (w < KEY_WORDS) begin : g_used
      assign key_words[w] = bus.key[16*w +: 16];
    end else begin : g_unused
      assign key_words[w] = 16'h0000;
    end
  end

  // Table length and iteration count derived from the requested round count.
  logic [4:0] r_clamp;
  logic [5:0] t_new;
  logic [5:0] tc_max;
  logic [6:0] n_new;
  always_comb begin
    r_clamp = (bus.num_rounds > 5'd16) ? 5'd16 : bus.num_rounds;
    t_new   = {r_clamp, 1'b0} + 6'd2;
    tc_max  = (t_new > {1'b0, C_WORDS}) ? t_new : {1'b0, C_WORDS};
    n_new   = {1'b0, tc_max} + {tc_max, 1'b0};
  end

  // One mixing iteration computed from the current A, B, S[i] and L[j].
  logic [15:0] a_new;
  logic [15:0] ab_sum;
  logic [15:0] b_new;
  always_comb begin
    a_new  = rotl16(s_q[i_q] + a_q + b_q, 4'd3);
    ab_sum = a_new + b_q;
    b_new  = rotl16(l_q[j_q] + ab_sum, ab_sum[3:0]);
  end

  // Next-state and datapath updates; every register holds unless its phase moves it.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    l_d     = l_q;
    a_d     = a_q;
    b_d     = b_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    t_d     = t_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          t_d     = t_new;
          n_d     = n_new;
          l_d     = key_words;
          s_d     = '0;
          a_d     = 16'h0000;
          b_d     = 16'h0000;
          i_d     = 6'd0;
          j_d     = 4'd0;
          k_d     = 6'd0;
          cnt_d   = 7'd0;
          valid_d = 1'b0;
          state_d = INIT;
        end
      end

      INIT: begin
        // Running add keeps the constant table to one adder.
        s_d[k_q] = (k_q == 6'd0) ? C_P16 : (s_q[k_q - 6'd1] + C_Q16);
        k_d      = k_q + 6'd1;
        if (k_q == t_q - 6'd1) begin
          state_d = MIX;
        end
      end

      MIX: begin
        s_d[i_q] = a_new;
        l_d[j_q] = b_new;
        a_d      = a_new;
        b_d      = b_new;
        i_d      = (i_q + 6'd1 == t_q) ? 6'd0 : (i_q + 6'd1);
        j_d      = ({1'b0, j_q} + 5'd1 == C_WORDS) ? 4'd0 : (j_q + 4'd1);
        cnt_d    = cnt_q + 7'd1;
        if (cnt_q == n_q - 7'd1) begin
          state_d = DONE;
        end
      end

      DONE: begin
        valid_d = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears the whole table and aborts any run.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      l_q     <= '0;
      a_q     <= 16'h0000;
      b_q     <= 16'h0000;
      i_q     <= 6'd0;
      j_q     <= 4'd0;
      k_q     <= 6'd0;
      t_q     <= 6'd0;
      n_q     <= 7'd0;
      cnt_q   <= 7'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      l_q     <= l_d;
      a_q     <= a_d;
      b_q     <= b_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      t_q     <= t_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign bus.subkeys       = s_q;
  assign bus.busy          = (state_q != IDLE);
  assign bus.done          = (state_q == DONE);
  assign bus.subkeys_valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_rc5_key_expand.sv
`default_nettype none
// ============================================================================
// Module      : tb_rc5_key_expand
// Description : Self-checking bench for rc5_key_expand. A reference model of
//               the RC5-16 key schedule tracks every accepted request and a
//               compare process checks busy/done/valid/subkeys each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rc5_key_expand;

  localparam int KW = 8;
  typedef logic [0:33][15:0] stab_t;

  logic clk = 1'b0;
  logic rst;
  logic cmp_en = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  rc5_key_expand_if #(.KEY_WORDS(KW)) bus ();
  rc5_key_expand #(.KEY_WORDS(KW)) dut (.clk(clk), .rst(rst), .bus(bus));

  // ---------------------------------------------------------------- model
  function automatic logic [15:0] rotl(input logic [15:0] x, input int s);
    logic [31:0] w;
    w = {x, x} << (s & 15);
    return w[31:16];
  endfunction

  function automatic stab_t init_tab(input int t);
    stab_t s;
    for (int q = 0; q < 34; q++)
      s[q] = (q < t) ? 16'(32'hB7E1 + q * 32'h9E37) : 16'h0000;
    return s;
  endfunction

  function automatic int t_of(input int r);
    int rp;
    rp = (r > 16) ? 16 : r;
    return 2 * (rp + 1);
  endfunction

  function automatic int n_of(input int r);
    int t;
    t = t_of(r);
    return 3 * ((t > KW) ? t : KW);
  endfunction

  function automatic stab_t expand(input logic [16*KW-1:0] key, input int r);
    int t, n, ii, jj;
    logic [15:0] L [KW];
    logic [15:0] A, B, ab;
    stab_t s;
    t = t_of(r);
    n = n_of(r);
    s = init_tab(t);
    for (int q = 0; q < KW; q++) L[q] = key[16*q +: 16];
    A = 0; B = 0; ii = 0; jj = 0;
    for (int q = 0; q < n; q++) begin
      A = rotl(s[ii] + A + B, 3);
      s[ii] = A;
      ab = A + B;
      B = rotl(L[jj] + ab, int'(ab));
      L[jj] = B;
      ii = (ii + 1) % t;
      jj = (jj + 1) % KW;
    end
    return s;
  endfunction

  function automatic logic [31:0] rc5_enc(input logic [31:0] pt, input stab_t s, input int r);
    logic [15:0] A, B;
    A = pt[15:0] + s[0];
    B = pt[31:16] + s[1];
    for (int i = 1; i <= r; i++) begin
      A = rotl(A ^ B, int'(B)) + s[2*i];
      B = rotl(B ^ A, int'(A)) + s[2*i+1];
    end
    return {B, A};
  endfunction

  function automatic logic [31:0] rc5_dec(input logic [31:0] ct, input stab_t s, input int r);
    logic [15:0] A, B;
    A = ct[15:0];
    B = ct[31:16];
    for (int i = r; i >= 1; i--) begin
      B = rotl(B - s[2*i+1], 16 - (int'(A) & 15)) ^ A;
      A = rotl(A - s[2*i], 16 - (int'(B) & 15)) ^ B;
    end
    B = B - s[1];
    A = A - s[0];
    return {B, A};
  endfunction

  // ------------------------------------------------------------- checkers
  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_tab(input string name, input stab_t act, input stab_t exp);
    int idx;
    checks++;
    if (act !== exp) begin
      failures++;
      idx = 0;
      for (int q = 33; q >= 0; q--) if (act[q] !== exp[q]) idx = q;
      $display("FAIL %s: S[%0d] got 0x%04h expected 0x%04h", name, idx, act[idx], exp[idx]);
    end
  endtask

  // Timeline model: m_cyc is the cycle number since accept (0 = idle).
  int    m_cyc = 0;
  int    m_lat = 0;
  int    m_t   = 2;
  bit    m_valid = 1'b0;
  stab_t m_init, m_final;

  // Advance the reference timeline on the same edge the DUT samples its inputs.
  always @(posedge clk) begin
    if (rst) begin
      m_cyc   = 0;
      m_valid = 1'b0;
    end else if (m_cyc != 0 && m_cyc == m_lat) begin
      m_cyc   = 0;
      m_valid = 1'b1;
    end else if (m_cyc != 0) begin
      m_cyc++;
    end else if (bus.start) begin
      m_t     = t_of(int'(bus.num_rounds));
      m_lat   = m_t + n_of(int'(bus.num_rounds)) + 1;
      m_init  = init_tab(m_t);
      m_final = expand(bus.key, int'(bus.num_rounds));
      m_valid = 1'b0;
      m_cyc   = 1;
    end
  end

  stab_t upper_mask_tab;
  // Compare DUT outputs against the timeline model mid-cycle.
  always @(negedge clk) begin
    if (cmp_en) begin
      check_int("busy", int'(bus.busy), (m_cyc != 0) ? 1 : 0);
      check_int("done", int'(bus.done), (m_cyc != 0 && m_cyc == m_lat) ? 1 : 0);
      if (!(m_cyc != 0 && m_cyc == m_lat))
        check_int("subkeys_valid", int'(bus.subkeys_valid), m_valid ? 1 : 0);
      if (m_cyc == 0) begin
        check_tab("idle_subkeys", bus.subkeys, m_valid ? m_final : stab_t'('0));
      end else if (m_cyc == 1) begin
        check_tab("cleared_on_accept", bus.subkeys, stab_t'('0));
      end else if (m_cyc == m_t + 1) begin
        check_tab("init_table", bus.subkeys, m_init);
      end else if (m_cyc == m_lat) begin
        check_tab("final_table", bus.subkeys, m_final);
      end else begin
        upper_mask_tab = bus.subkeys;
        for (int q = 0; q < 34; q++) if (q < m_t) upper_mask_tab[q] = 16'h0000;
        check_tab("unused_entries_zero", upper_mask_tab, stab_t'('0));
      end
    end
  end

  // -------------------------------------------------------------- stimulus
  function automatic logic [16*KW-1:0] rand_key();
    logic [16*KW-1:0] k;
    for (int w = 0; w < KW / 2; w++) k[32*w +: 32] = $urandom;
    return k;
  endfunction

  task automatic run(input logic [16*KW-1:0] key, input int r, input bit hold_start,
                     input bit lit, output int lat);
    bit got;
    @(negedge clk);
    bus.key        = key;
    bus.num_rounds = 5'(r);
    bus.start      = 1'b1;
    @(posedge clk);
    got = 1'b0;
    lat = -1;
    for (int c = 1; c <= 300 && !got; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.key        = rand_key();
        bus.num_rounds = 5'($urandom);
      end
      if (!hold_start || bus.done) bus.start = 1'b0;
      if (lit && c == 35) begin
        check_int("lit_S0_init",  int'(bus.subkeys[0]),  'hB7E1);
        check_int("lit_S1_init",  int'(bus.subkeys[1]),  'h5618);
        check_int("lit_S2_init",  int'(bus.subkeys[2]),  'hF44F);
        check_int("lit_S33_init", int'(bus.subkeys[33]), 'h1CF8);
      end
      if (lit && c == 36) check_int("lit_S0_mix1", int'(bus.subkeys[0]), 'hBF0D);
      if (bus.done) begin
        got = 1'b1;
        lat = c;
      end
    end
    bus.start = 1'b0;
    if (!got) begin
      failures++;
      $display("FAIL done_timeout: got no done expected done within 300 cycles");
    end
    @(negedge clk);
  endtask

  int          lat;
  int          d1, d2;
  int          rl [5]  = '{0, 1, 12, 16, 20};
  int          el [5]  = '{27, 29, 105, 137, 137};
  stab_t       ks;
  logic [31:0] ct, rt;
  logic [16*KW-1:0] kk;

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.num_rounds = 5'd0;
    bus.key = '0;

    // Pin the model itself with hand-computed values.
    ks = init_tab(34);
    check_int("model_S1",  int'(ks[1]),  'h5618);
    check_int("model_S33", int'(ks[33]), 'h1CF8);
    check_int("model_rotl", int'(rotl(16'hB7E1, 3)), 'hBF0D);
    check_int("model_lat_r12", t_of(12) + n_of(12) + 1, 105);

    // Reset for three cycles with a start pulse that must be ignored.
    @(posedge clk);
    #1 cmp_en = 1'b1;
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk); rst = 1'b0;
    repeat (4) @(negedge clk);

    // INIT literals and first MIX step with an all-zero key.
    run('0, 16, 1'b0, 1'b1, lat);
    check_int("lat_key0_r16", lat, 137);

    // Random keys across round counts, including the clamped r=20.
    for (int q = 0; q < 5; q++) begin
      run(rand_key(), rl[q], (rl[q] == 12), 1'b0, lat);
      check_int($sformatf("lat_r%0d", rl[q]), lat, el[q]);
      repeat (3) @(negedge clk);
    end

    // Round trip through the cipher with r=12 subkeys.
    kk = rand_key();
    run(kk, 12, 1'b0, 1'b0, lat);
    ks = bus.subkeys;
    ct = rc5_enc(32'h12345678, ks, 12);
    rt = rc5_dec(ct, ks, 12);
    check_int("roundtrip", int'(rt), 'h12345678);
    check_int("ciphertext", int'(ct), int'(rc5_enc(32'h12345678, expand(kk, 12), 12)));

    // Abort mid-MIX with reset.
    @(negedge clk);
    bus.key = rand_key(); bus.num_rounds = 5'd12; bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    repeat (38) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_int("abort_busy",  int'(bus.busy), 0);
    check_int("abort_valid", int'(bus.subkeys_valid), 0);
    check_tab("abort_subkeys", bus.subkeys, stab_t'('0));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Back-to-back: start held high restarts right after DONE.
    bus.key = rand_key(); bus.num_rounds = 5'd0; bus.start = 1'b1;
    d1 = -1; d2 = -1;
    for (int c = 0; c < 200 && d2 < 0; c++) begin
      @(negedge clk);
      if (bus.done) begin
        if (d1 < 0) d1 = c;
        else begin
          d2 = c;
          bus.start = 1'b0;
        end
      end
    end
    bus.start = 1'b0;
    check_int("b2b_gap", d2 - d1, 28);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
